// File: rtl/logic_unit_pipe.sv
// Pipelined 8-operation bitwise logic unit: zero flag, valid/ready on both sides, saturating op counter.
// Define LOGIC_PARITY_EN to add the pipelined logic_parity output (XOR-reduction of the result).
module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_FUN,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] logic_out,
  output logic             logic_zero,
  output logic             logic_flag,
  input  logic             out_ready,
`ifdef LOGIC_PARITY_EN
  output logic             logic_parity,
`endif
  output logic [CNT_W-1:0] op_count
);

`ifdef LOGIC_PARITY_EN
  localparam int TAG_W = 2;
`else
  localparam int TAG_W = 1;
`endif
  localparam int WORD_W = WIDTH + TAG_W;

  function automatic logic [WIDTH-1:0] bit_op(input logic [2:0] fn,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (fn)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Result travels with its flag bit(s) above it: {parity, zero, result}.
  function automatic logic [WORD_W-1:0] pack_word(input logic [WIDTH-1:0] r);
`ifdef LOGIC_PARITY_EN
    return {^r, ~|r, r};
`else
    return {~|r, r};
`endif
  endfunction

  logic [WORD_W-1:0] word_p [STAGES];
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv;
  logic [WORD_W-1:0] word_in;
  logic              done;

  assign word_in = pack_word(bit_op(ALU_FUN, A, B));

  // A stage advances if it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      go     = go || !vld_p[k];
      adv[k] = go;
    end
  end

  assign in_ready = adv[0];
  assign done     = logic_flag && out_ready;

  // stage 1 captures the computed word; stages 2..STAGES are pure delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p    <= '0;
      op_count <= '0;
      for (int k = 0; k < STAGES; k++) word_p[k] <= '0;
    end else begin
      if (adv[0]) begin
        vld_p[0] <= in_valid;
        if (in_valid) word_p[0] <= word_in;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_p[k] <= vld_p[k-1];
          if (vld_p[k-1]) word_p[k] <= word_p[k-1];
        end
      end
      if (done && op_count != {CNT_W{1'b1}}) op_count <= op_count + CNT_W'(1);
    end
  end

  assign logic_out  = word_p[STAGES-1][WIDTH-1:0];
  assign logic_zero = word_p[STAGES-1][WIDTH];
  assign logic_flag = vld_p[STAGES-1];
`ifdef LOGIC_PARITY_EN
  assign logic_parity = word_p[STAGES-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a 2-stage instance (u0) and a 4-stage, 4-bit-counter instance (u1).
module tb_logic_unit_pipe;
  localparam int W  = 16;
  localparam int S0 = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [W-1:0] a0, b0, out0, a1, b1, out1;
  logic [2:0]   fn0, fn1;
  logic iv0, ir0, z0, f0, or0;
  logic iv1, ir1, z1, f1, or1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
`ifdef LOGIC_PARITY_EN
  logic p0, p1;
`endif

  int tests = 0;
  int fails = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .STAGES(2), .CNT_W(16)) u0 (
    .clk(clk), .reset_n(reset_n), .A(a0), .B(b0), .ALU_FUN(fn0),
    .in_valid(iv0), .in_ready(ir0), .logic_out(out0), .logic_zero(z0),
    .logic_flag(f0), .out_ready(or0),
`ifdef LOGIC_PARITY_EN
    .logic_parity(p0),
`endif
    .op_count(cnt0));

  logic_unit_pipe #(.WIDTH(W), .STAGES(4), .CNT_W(4)) u1 (
    .clk(clk), .reset_n(reset_n), .A(a1), .B(b1), .ALU_FUN(fn1),
    .in_valid(iv1), .in_ready(ir1), .logic_out(out1), .logic_zero(z1),
    .logic_flag(f1), .out_ready(or1),
`ifdef LOGIC_PARITY_EN
    .logic_parity(p1),
`endif
    .op_count(cnt1));

  function automatic logic [W-1:0] ref_op(input logic [2:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    case (fn)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    tests++; if (f0 !== 1'b0) begin fails++; $display("FAIL reset_flag got %b exp 0", f0); end
    tests++; if (out0 !== '0) begin fails++; $display("FAIL reset_out got %h exp 0000", out0); end
    tests++; if (z0 !== 1'b0) begin fails++; $display("FAIL reset_zero got %b exp 0", z0); end
    tests++; if (cnt0 !== 16'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", cnt0); end
    tests++; if (ir0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", ir0); end
    tests++; if (f1 !== 1'b0 || cnt1 !== 4'd0) begin fails++; $display("FAIL reset_u1 got flag %b cnt %0d exp 0 0", f1, cnt1); end
    @(negedge clk);
  endtask

  task automatic test_opcode_sweep();
    logic [W-1:0] tbl [8];
    tbl = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F, 16'h0FF0, 16'hF00F, 16'h0F0F, 16'hF0F0};
    or0 = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c < 10) begin
        tests++;
        if (f0 !== 1'b1 || out0 !== tbl[c-2])
          begin fails++; $display("FAIL sweep_op%0d got flag %b out %h exp 1 %h", c-2, f0, out0, tbl[c-2]); end
      end else begin
        tests++; if (f0 !== 1'b0) begin fails++; $display("FAIL sweep_idle%0d got flag %b exp 0", c, f0); end
      end
      if (c < 8) begin iv0 = 1'b1; a0 = 16'hF0F0; b0 = 16'hFF00; fn0 = 3'(c); end
      else iv0 = 1'b0;
      @(negedge clk);
    end
    exp_cnt0 = 8;
    tests++; if (cnt0 !== 16'(exp_cnt0)) begin fails++; $display("FAIL sweep_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_zero_flag();
    or0 = 1'b1;
    iv0 = 1'b1; a0 = 16'h00FF; b0 = 16'hFF00; fn0 = 3'b000;
    @(negedge clk);
    a0 = 16'h0007; b0 = 16'h1234; fn0 = 3'b111;
    @(negedge clk);
    iv0 = 1'b0;
    tests++; if (f0 !== 1'b1 || out0 !== 16'h0000 || z0 !== 1'b1)
      begin fails++; $display("FAIL zero_set got flag %b out %h zero %b exp 1 0000 1", f0, out0, z0); end
    @(negedge clk);
    tests++; if (f0 !== 1'b1 || out0 !== 16'h0007 || z0 !== 1'b0)
      begin fails++; $display("FAIL zero_clear got flag %b out %h zero %b exp 1 0007 0", f0, out0, z0); end
`ifdef LOGIC_PARITY_EN
    tests++; if (p0 !== 1'b1) begin fails++; $display("FAIL parity got %b exp 1", p0); end
`endif
    @(negedge clk);
    exp_cnt0 += 2;
    tests++; if (cnt0 !== 16'(exp_cnt0)) begin fails++; $display("FAIL zero_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int k;
    int hs;
    k = 0; hs = 0;
    or0 = 1'b0; iv0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a0 = 16'h1000 + 16'(k); b0 = W'($urandom); fn0 = 3'($urandom_range(7));
      #1;
      if (c >= 2) begin
        tests++;
        if (f0 !== 1'b1 || out0 !== q0[0])
          begin fails++; $display("FAIL bp_hold%0d got flag %b out %h exp 1 %h", c, f0, out0, q0[0]); end
      end
      if (ir0) begin q0.push_back(ref_op(fn0, a0, b0)); k++; end
      @(negedge clk);
    end
    tests++; if (k != S0) begin fails++; $display("FAIL bp_accepts got %0d exp %0d", k, S0); end
    a0 = 16'h2000; #1;
    tests++; if (ir0 !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b exp 0", ir0); end
    or0 = 1'b1; #1;
    tests++; if (ir0 !== 1'b1 || f0 !== 1'b1 || out0 !== q0[0])
      begin fails++; $display("FAIL bp_release got ready %b flag %b out %h exp 1 1 %h", ir0, f0, out0, q0[0]); end
    e = q0.pop_front(); hs++;
    q0.push_back(ref_op(fn0, a0, b0));
    @(negedge clk);
    or0 = 1'b0; iv0 = 1'b0; #1;
    tests++; if (f0 !== 1'b1 || out0 !== q0[0] || ir0 !== 1'b0)
      begin fails++; $display("FAIL bp_after got flag %b out %h ready %b exp 1 %h 0", f0, out0, ir0, q0[0]); end
    or0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (f0) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL bp_extra got %h exp none", out0); end
        else begin
          e = q0.pop_front(); hs++;
          if (out0 !== e) begin fails++; $display("FAIL bp_order got %h exp %h", out0, e); end
        end
      end
      @(negedge clk);
    end
    tests++; if (q0.size() != 0) begin fails++; $display("FAIL bp_drain got %0d left exp 0", q0.size()); end
    exp_cnt0 += hs;
    tests++; if (cnt0 !== 16'(exp_cnt0)) begin fails++; $display("FAIL bp_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_bubbles();
    logic [W-1:0] first, e;
    int n;
    int hs;
    or1 = 1'b0; iv1 = 1'b1; a1 = 16'h1234; b1 = 16'h0F0F; fn1 = 3'b100;
    first = ref_op(fn1, a1, b1);
    #1;
    tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL bub_ready0 got %b exp 1", ir1); end
    q1.push_back(first);
    @(negedge clk);
    iv1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      tests++; if (f1 !== (c == 4)) begin fails++; $display("FAIL bub_flag%0d got %b exp %b", c, f1, c == 4); end
      if (c < 4) begin
        tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL bub_ready%0d got %b exp 1", c, ir1); end
      end
      @(negedge clk);
    end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      iv1 = 1'b1; a1 = W'($urandom); b1 = W'($urandom); fn1 = 3'($urandom_range(7));
      #1;
      tests++; if (f1 !== 1'b1 || out1 !== first)
        begin fails++; $display("FAIL bub_hold got flag %b out %h exp 1 %h", f1, out1, first); end
      if (!ir1) break;
      q1.push_back(ref_op(fn1, a1, b1)); n++;
      @(negedge clk);
    end
    tests++; if (n != 3) begin fails++; $display("FAIL bub_fill got %0d exp 3", n); end
    iv1 = 1'b0; or1 = 1'b1; hs = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (f1) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL bub_extra got %h exp none", out1); end
        else begin
          e = q1.pop_front(); hs++;
          if (out1 !== e || z1 !== (e == '0)) begin fails++; $display("FAIL bub_order got %h exp %h", out1, e); end
        end
      end
      @(negedge clk);
    end
    tests++; if (hs != 4) begin fails++; $display("FAIL bub_drain got %0d exp 4", hs); end
    exp_cnt1 = hs;
    tests++; if (cnt1 !== 4'(exp_cnt1)) begin fails++; $display("FAIL bub_count got %0d exp %0d", cnt1, exp_cnt1); end
  endtask

  task automatic test_counter_saturation();
    int hs;
    hs = 0; or1 = 1'b1;
    for (int c = 0; c < 26; c++) begin
      iv1 = (c < 20); a1 = W'($urandom); b1 = W'($urandom); fn1 = 3'($urandom_range(7));
      #1;
      if (c < 20) begin
        tests++; if (ir1 !== 1'b1) begin fails++; $display("FAIL sat_ready%0d got %b exp 1", c, ir1); end
      end
      if (f1) hs++;
      @(negedge clk);
    end
    tests++; if (hs != 20) begin fails++; $display("FAIL sat_outputs got %0d exp 20", hs); end
    exp_cnt1 = (exp_cnt1 + hs > 15) ? 15 : exp_cnt1 + hs;
    tests++; if (cnt1 !== 4'(exp_cnt1)) begin fails++; $display("FAIL sat_count got %0d exp %0d", cnt1, exp_cnt1); end
  endtask

  task automatic test_random();
    logic [W-1:0] e, held;
    logic stalled;
    stalled = 1'b0; held = '0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        iv0 = ($urandom_range(3) != 0); or0 = ($urandom_range(2) != 0);
        a0 = W'($urandom); b0 = W'($urandom); fn0 = 3'($urandom_range(7));
      end else begin
        iv0 = 1'b0; or0 = 1'b1;
      end
      #1;
      if (stalled) begin
        tests++; if (f0 !== 1'b1 || out0 !== held)
          begin fails++; $display("FAIL rnd_stall got flag %b out %h exp 1 %h", f0, out0, held); end
      end
      tests++; if (ir0 !== (q0.size() < S0 || or0))
        begin fails++; $display("FAIL rnd_ready got %b exp %b (held %0d)", ir0, q0.size() < S0 || or0, q0.size()); end
      if (q0.size() == 0) begin
        tests++; if (f0 !== 1'b0) begin fails++; $display("FAIL rnd_empty_flag got %b exp 0", f0); end
      end
      if (f0 && or0) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL rnd_extra got %h exp none", out0); end
        else begin
          e = q0.pop_front(); exp_cnt0++;
          if (out0 !== e || z0 !== (e == '0))
            begin fails++; $display("FAIL rnd_data got %h/%b exp %h/%b", out0, z0, e, e == '0); end
`ifdef LOGIC_PARITY_EN
          if (p0 !== ^e) begin fails++; $display("FAIL rnd_parity got %b exp %b", p0, ^e); end
`endif
        end
      end
      if (iv0 && ir0) q0.push_back(ref_op(fn0, a0, b0));
      stalled = f0 && !or0; held = out0;
      @(negedge clk);
    end
    tests++; if (q0.size() != 0) begin fails++; $display("FAIL rnd_drain got %0d left exp 0", q0.size()); end
    tests++; if (cnt0 !== 16'(exp_cnt0)) begin fails++; $display("FAIL rnd_count got %0d exp %0d", cnt0, exp_cnt0); end
  endtask

  task automatic test_reset_midstream();
    or0 = 1'b0; iv0 = 1'b1; a0 = 16'hABCD; b0 = 16'h1111; fn0 = 3'b001;
    @(negedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    tests++; if (f0 !== 1'b0 || out0 !== '0 || z0 !== 1'b0 || cnt0 !== 16'd0)
      begin fails++; $display("FAIL rst_async got flag %b out %h zero %b cnt %0d exp 0 0000 0 0", f0, out0, z0, cnt0); end
    tests++; if (cnt1 !== 4'd0) begin fails++; $display("FAIL rst_u1_count got %0d exp 0", cnt1); end
    @(negedge clk);
    reset_n = 1'b1; or0 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      tests++; if (f0 !== 1'b0) begin fails++; $display("FAIL rst_stale%0d got flag %b out %h exp 0", c, f0, out0); end
      @(negedge clk);
    end
    tests++; if (cnt0 !== 16'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", cnt0); end
  endtask

  initial begin
    reset_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0; fn0 = '0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; fn1 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_opcode_sweep();
    test_zero_flag();
    test_backpressure();
    test_bubbles();
    test_counter_saturation();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle logic unit in the ALU hierarchy.
- Extends the opcode set to eight bitwise operations and adds a zero flag.
- Adds a configurable-depth register pipeline with valid/ready handshake on both sides and full backpressure.
- Sits between the ALU decoder (upstream) and the ALU result mux/writeback (downstream); throughput is one operation per clock.

Parameters:
- WIDTH, 16: operand and result width in bits (legal 2..64).
- STAGES, 2: pipeline depth in register stages, equal to latency in cycles (legal 1..4).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALU_FUN  in  3  opcode
- in_valid  in  1  upstream presents A/B/ALU_FUN
- in_ready  out  1  unit accepts this cycle
- logic_out  out  WIDTH  result
- logic_zero  out  1  result == 0
- logic_flag  out  1  output valid
- out_ready  in  1  downstream accepts this cycle
- op_count  out  CNT_W  completed output handshakes, saturating

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values: all stage valid bits 0, logic_flag 0, logic_out 0, logic_zero 0, op_count 0.
- Reset mid-operation: in-flight operations are discarded and are not counted.
- Opcodes:
  - 000 A&B
  - 001 A|B
  - 010 ~(A&B)
  - 011 ~(A|B)
  - 100 A^B
  - 101 ~(A^B)
  - 110 ~A
  - 111 A (pass)
- Result width: always WIDTH; no carry and no sign handling.
- Input handshake: an operation is accepted when in_valid && in_ready.
- Output handshake: an operation completes when logic_flag && out_ready.
- Pipeline structure:
  - The operation is computed combinationally from the inputs and captured in stage 1 together with its zero bit.
  - Stages 2..STAGES are pure delay registers.
  - The last stage drives logic_out, logic_zero and logic_flag.
- Advance rule: stage k loads from stage k-1 (or from the inputs for k=1) when stage k is empty or stage k+1 will advance. The last stage advances when it is empty or out_ready is high.
- Bubble collapsing: an empty stage always accepts, so bubbles collapse under backpressure.
- in_ready: high when stage 1 will advance. It is combinational from out_ready and the stage valid bits; no combinational path from in_valid.
- Latency: with out_ready held high, a result appears on logic_flag exactly STAGES cycles after acceptance. Back-to-back inputs give back-to-back outputs.
- Stall hold: while logic_flag && !out_ready, logic_out, logic_zero and logic_flag hold stable.
- Accept under full backpressure: when the pipeline is full, a new input is accepted only in the same cycle as the output handshake.
- Data when not valid: logic_out and logic_zero keep their last loaded value while logic_flag is 0. Downstream qualifies them with logic_flag.
- Pipeline holding: up to STAGES operations.
- op_count:
  - Increments by 1 on each output handshake.
  - Saturates at 2^CNT_W-1.
  - Does not change on accept.
- Unused opcode bits: none; all 8 codes are defined. Inputs presented with in_valid=0 have no effect.

Optional Feature:
- Macro: LOGIC_PARITY_EN.
- Defined:
  - Adds output port logic_parity (out, 1) = XOR-reduction of the result.
  - Pipelined alongside logic_out; same latency and hold rules; reset value 0.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset: assert reset_n=0 mid-stream with 2 ops in flight -> logic_flag=0, logic_out=0, op_count=0 immediately (async). After release, no stale result emerges.
- Opcode sweep: WIDTH=16, STAGES=2, out_ready=1, A=16'hF0F0, B=16'hFF00, ALU_FUN 000..111 on consecutive cycles -> outputs 2 cycles later, in order:
  - 16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F
  - 16'h0FF0, 16'hF00F, 16'h0F0F, 16'hF0F0
  - all 8 on consecutive cycles; op_count=8.
- Zero flag: A=16'h00FF, B=16'hFF00, ALU_FUN=000 -> logic_out=0, logic_zero=1. With LOGIC_PARITY_EN, A=16'h0007, ALU_FUN=111 -> logic_parity=1.
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly STAGES ops accepted, then in_ready=0. logic_out holds the first result unchanged. Then raise out_ready for 1 cycle -> one output handshake and one new accept in that cycle; order is preserved.
- Bubbles: STAGES=4, single op, then in_valid=0 for 3 cycles with out_ready=0 -> the op reaches the last stage after 4 cycles and stays valid. in_ready stays 1 until 4 ops are held.
- Counter saturation: CNT_W=4, 20 completed ops -> op_count stops at 15.
